power_sequencer: RTL and testbench

Synthesizable replacement for the hand-driven power-cycle stimulus. It generates the G-15 power-on control sequence on the power-cycle inputs of g15_top: CLEAR, the OP sequence, timing-track read-in via ATS, number-track write via NT, loader-block read-in via ATS, and GO. Timing is measured in ms ticks from the timer block. Completion of each tape read is detected from the tape reader's PL6_WAIT_FOR_TAPE. It sits between timer/tape_reader and g15_top and drives the power-cycle and GO switch lines.

---
 rtl/power_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_power_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// G-15 power-on sequencer: drives CLEAR, the OP pulse, timing-track and loader reads, the number-track write and GO.
// The sequence steps on ms tick edges and waits on the tape reader's WAIT line for each tape read.
module power_sequencer #(
    parameter int CLEAR_TICKS   = 150,
    parameter int PRE_OP_TICKS  = 30,
    parameter int OP_TICKS      = 60,
    parameter int POST_OP_TICKS = 30,
    parameter int SETTLE_TICKS  = 120,
    parameter int ATS_TICKS     = 30,
    parameter int NT_TICKS      = 120,
    parameter int TAPE_TIMEOUT  = 20000,
    parameter int CW            = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic       PL6_WAIT_FOR_TAPE,
    output logic       PWR_CLEAR,
    output logic       PWR_NO_CLEAR,
    output logic       PWR_OP,
    output logic       PWR_NO_OP,
    output logic       PWR_ATS,
    output logic       PWR_NT,
    output logic       SW_GO,
    output logic       done,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CLEAR   = 4'd1,
        ST_PRE_OP  = 4'd2,
        ST_OP      = 4'd3,
        ST_POST_OP = 4'd4,
        ST_SET1    = 4'd5,
        ST_ATS1    = 4'd6,
        ST_WAIT_TT = 4'd7,
        ST_SET2    = 4'd8,
        ST_NT      = 4'd9,
        ST_SET3    = 4'd10,
        ST_ATS2    = 4'd11,
        ST_WAIT_LD = 4'd12,
        ST_SET4    = 4'd13,
        ST_GO      = 4'd14,
        ST_FAULT   = 4'd15
    } state_t;

    // A zero duration would never match counter==N-1, so clamp it to one tick.
    function automatic int non_zero(input int p);
        return (p <= 0) ? 1 : p;
    endfunction

    localparam logic [CW-1:0] CLEAR_LIM   = CW'(non_zero(CLEAR_TICKS) - 1);
    localparam logic [CW-1:0] PRE_OP_LIM  = CW'(non_zero(PRE_OP_TICKS) - 1);
    localparam logic [CW-1:0] OP_LIM      = CW'(non_zero(OP_TICKS) - 1);
    localparam logic [CW-1:0] POST_OP_LIM = CW'(non_zero(POST_OP_TICKS) - 1);
    localparam logic [CW-1:0] SETTLE_LIM  = CW'(non_zero(SETTLE_TICKS) - 1);
    localparam logic [CW-1:0] ATS_LIM     = CW'(non_zero(ATS_TICKS) - 1);
    localparam logic [CW-1:0] NT_LIM      = CW'(non_zero(NT_TICKS) - 1);
    localparam logic [CW-1:0] TIMEOUT_LIM = CW'(non_zero(TAPE_TIMEOUT) - 1);

    function automatic logic [CW-1:0] limit_of(input state_t s);
        logic [CW-1:0] lim;
        lim = SETTLE_LIM;
        case (s)
            ST_CLEAR:   lim = CLEAR_LIM;
            ST_PRE_OP:  lim = PRE_OP_LIM;
            ST_OP:      lim = OP_LIM;
            ST_POST_OP: lim = POST_OP_LIM;
            ST_ATS1,
            ST_ATS2:    lim = ATS_LIM;
            ST_NT:      lim = NT_LIM;
            default:    lim = SETTLE_LIM;
        endcase
        return lim;
    endfunction

    function automatic state_t next_of(input state_t s);
        state_t n;
        n = s;
        case (s)
            ST_IDLE:    n = ST_CLEAR;
            ST_CLEAR:   n = ST_PRE_OP;
            ST_PRE_OP:  n = ST_OP;
            ST_OP:      n = ST_POST_OP;
            ST_POST_OP: n = ST_SET1;
            ST_SET1:    n = ST_ATS1;
            ST_ATS1:    n = ST_WAIT_TT;
            ST_WAIT_TT: n = ST_SET2;
            ST_SET2:    n = ST_NT;
            ST_NT:      n = ST_SET3;
            ST_SET3:    n = ST_ATS2;
            ST_ATS2:    n = ST_WAIT_LD;
            ST_WAIT_LD: n = ST_SET4;
            ST_SET4:    n = ST_GO;
            default:    n = s;
        endcase
        return n;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;
    logic          tick_q;
    logic          seen_q, seen_d;
    logic          tick_e;

    logic pwr_clear_q, pwr_clear_d;
    logic pwr_no_clear_q, pwr_no_clear_d;
    logic pwr_op_q, pwr_op_d;
    logic pwr_no_op_q, pwr_no_op_d;
    logic pwr_ats_q, pwr_ats_d;
    logic pwr_nt_q, pwr_nt_d;
    logic sw_go_q, sw_go_d;
    logic done_q, done_d;
    logic fault_q, fault_d;

    assign tick_e = tick & ~tick_q;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        seen_d    = seen_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CLEAR;
                    counter_d = '0;
                    seen_d    = 1'b0;
                end
            end
            ST_WAIT_TT, ST_WAIT_LD: begin
                seen_d = seen_q | PL6_WAIT_FOR_TAPE;
                // Completion is tested first so it beats a coincident timeout.
                if (seen_q && !PL6_WAIT_FOR_TAPE) begin
                    state_d   = next_of(state_q);
                    counter_d = '0;
                    seen_d    = 1'b0;
                end else if (tick_e) begin
                    if (counter_q == TIMEOUT_LIM) begin
                        state_d   = ST_FAULT;
                        counter_d = '0;
                        seen_d    = 1'b0;
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
            ST_GO, ST_FAULT: begin
                state_d = state_q;
            end
            default: begin
                if (tick_e) begin
                    if (counter_q == limit_of(state_q)) begin
                        state_d   = next_of(state_q);
                        counter_d = '0;
                        seen_d    = 1'b0;
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
        endcase
        if (abort) begin
            state_d   = ST_IDLE;
            counter_d = '0;
            seen_d    = 1'b0;
        end
    end

    // Outputs decode from the next state so they update on the same edge as state_q.
    always_comb begin
        pwr_clear_d    = 1'b0;
        pwr_no_clear_d = 1'b1;
        pwr_op_d       = 1'b0;
        pwr_no_op_d    = 1'b1;
        pwr_ats_d      = 1'b0;
        pwr_nt_d       = 1'b0;
        sw_go_d        = 1'b0;
        done_d         = 1'b0;
        fault_d        = 1'b0;
        case (state_d)
            ST_CLEAR: begin
                pwr_clear_d    = 1'b1;
                pwr_no_clear_d = 1'b0;
            end
            ST_PRE_OP, ST_POST_OP: begin
                pwr_no_op_d = 1'b0;
            end
            ST_OP: begin
                pwr_op_d    = 1'b1;
                pwr_no_op_d = 1'b0;
            end
            ST_ATS1, ST_ATS2: begin
                pwr_ats_d = 1'b1;
            end
            ST_NT: begin
                pwr_nt_d = 1'b1;
            end
            ST_GO: begin
                sw_go_d = 1'b1;
                done_d  = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pwr_clear_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            tick_q         <= 1'b0;
            seen_q         <= 1'b0;
            pwr_clear_q    <= 1'b0;
            pwr_no_clear_q <= 1'b1;
            pwr_op_q       <= 1'b0;
            pwr_no_op_q    <= 1'b1;
            pwr_ats_q      <= 1'b0;
            pwr_nt_q       <= 1'b0;
            sw_go_q        <= 1'b0;
            done_q         <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            tick_q         <= tick;
            seen_q         <= seen_d;
            pwr_clear_q    <= pwr_clear_d;
            pwr_no_clear_q <= pwr_no_clear_d;
            pwr_op_q       <= pwr_op_d;
            pwr_no_op_q    <= pwr_no_op_d;
            pwr_ats_q      <= pwr_ats_d;
            pwr_nt_q       <= pwr_nt_d;
            sw_go_q        <= sw_go_d;
            done_q         <= done_d;
            fault_q        <= fault_d;
        end
    end

    assign PWR_CLEAR    = pwr_clear_q;
    assign PWR_NO_CLEAR = pwr_no_clear_q;
    assign PWR_OP       = pwr_op_q;
    assign PWR_NO_OP    = pwr_no_op_q;
    assign PWR_ATS      = pwr_ats_q;
    assign PWR_NT       = pwr_nt_q;
    assign SW_GO        = sw_go_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign state        = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer with short durations: a table walks the full power-on sequence,
// and hand-written sequences cover timeout, abort, tick-level filtering and completion/timeout races.
module tb_power_sequencer;

    logic       clk = 1'b0;
    logic       rst, tick, start, abort, pl6;
    logic       PWR_CLEAR, PWR_NO_CLEAR, PWR_OP, PWR_NO_OP, PWR_ATS, PWR_NT;
    logic       SW_GO, done, fault;
    logic [3:0] state;
    logic [8:0] out_vec;

    int errors = 0;
    int checks = 0;
    int inv_bad = 0;

    // Output vector order: {CLEAR, NO_CLEAR, OP, NO_OP, ATS, NT, GO, done, fault}
    localparam logic [8:0] O_REST  = 9'b010100000;
    localparam logic [8:0] O_CLEAR = 9'b100100000;
    localparam logic [8:0] O_NOOP  = 9'b010000000;
    localparam logic [8:0] O_OP    = 9'b011000000;
    localparam logic [8:0] O_ATS   = 9'b010110000;
    localparam logic [8:0] O_NT    = 9'b010101000;
    localparam logic [8:0] O_GO    = 9'b010100110;
    localparam logic [8:0] O_FAULT = 9'b010100001;

    typedef struct {
        string      name;
        logic       pl6;
        int         ticks;
        logic [3:0] exp_state;
        logic [8:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    power_sequencer #(
        .CLEAR_TICKS(3), .PRE_OP_TICKS(2), .OP_TICKS(4), .POST_OP_TICKS(2),
        .SETTLE_TICKS(5), .ATS_TICKS(2), .NT_TICKS(6), .TAPE_TIMEOUT(50), .CW(16)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
        .PL6_WAIT_FOR_TAPE(pl6),
        .PWR_CLEAR(PWR_CLEAR), .PWR_NO_CLEAR(PWR_NO_CLEAR), .PWR_OP(PWR_OP),
        .PWR_NO_OP(PWR_NO_OP), .PWR_ATS(PWR_ATS), .PWR_NT(PWR_NT),
        .SW_GO(SW_GO), .done(done), .fault(fault), .state(state)
    );

    assign out_vec = {PWR_CLEAR, PWR_NO_CLEAR, PWR_OP, PWR_NO_OP, PWR_ATS, PWR_NT, SW_GO, done, fault};

    always #5 clk = ~clk;

    // Structural invariants sampled every cycle.
    always @(negedge clk) begin
        if (PWR_OP && PWR_NO_OP) inv_bad++;
        if (PWR_NO_CLEAR == PWR_CLEAR) inv_bad++;
        if ($countones({PWR_CLEAR, PWR_OP, PWR_ATS, PWR_NT}) > 1) inv_bad++;
    end

    function automatic void add(input string n, input logic p, input int t,
                                input logic [3:0] s, input logic [8:0] o);
        vec_t v;
        v.name = n; v.pl6 = p; v.ticks = t; v.exp_state = s; v.exp_out = o;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] es, input logic [8:0] eo);
        checks++;
        if (state !== es) begin
            errors++;
            $display("[TB] FAIL %s state: got %0d expected %0d", name, state, es);
        end
        checks++;
        if (out_vec !== eo) begin
            errors++;
            $display("[TB] FAIL %s outputs: got %b expected %b", name, out_vec, eo);
        end
    endtask

    task automatic doTick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic runTicks(input int n);
        repeat (n) doTick();
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        pl6 = v.pl6;
        runTicks(v.ticks);
    endtask

    task automatic doReset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; pl6 = 1'b0; tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic startSeq();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        add("clear_mid",     0, 2, 4'd1,  O_CLEAR);
        add("pre_op",        0, 1, 4'd2,  O_NOOP);
        add("pre_op_hold",   0, 1, 4'd2,  O_NOOP);
        add("op",            0, 1, 4'd3,  O_OP);
        add("op_hold",       0, 3, 4'd3,  O_OP);
        add("post_op",       0, 1, 4'd4,  O_NOOP);
        add("post_op_hold",  0, 1, 4'd4,  O_NOOP);
        add("set1",          0, 1, 4'd5,  O_REST);
        add("set1_hold",     0, 4, 4'd5,  O_REST);
        add("ats1",          0, 1, 4'd6,  O_ATS);
        add("ats1_hold",     0, 1, 4'd6,  O_ATS);
        add("wait_tt",       0, 1, 4'd7,  O_REST);
        add("wait_tt_idle",  0, 3, 4'd7,  O_REST);
        add("wait_tt_busy",  1, 10, 4'd7, O_REST);
        add("set2",          0, 0, 4'd8,  O_REST);
        add("set2_hold",     0, 4, 4'd8,  O_REST);
        add("nt",            0, 1, 4'd9,  O_NT);
        add("nt_hold",       0, 5, 4'd9,  O_NT);
        add("set3",          0, 1, 4'd10, O_REST);
        add("set3_hold",     0, 4, 4'd10, O_REST);
        add("ats2",          0, 1, 4'd11, O_ATS);
        add("ats2_hold",     0, 1, 4'd11, O_ATS);
        add("wait_ld",       0, 1, 4'd12, O_REST);
        add("wait_ld_idle",  0, 3, 4'd12, O_REST);
        add("wait_ld_busy",  1, 10, 4'd12, O_REST);
        add("set4",          0, 0, 4'd13, O_REST);
        add("set4_hold",     0, 4, 4'd13, O_REST);
        add("go",            0, 1, 4'd14, O_GO);
        add("go_hold",       0, 3, 4'd14, O_GO);

        // Reset held across ten tick edges must leave everything at rest.
        rst = 1'b1; start = 1'b0; abort = 1'b0; pl6 = 1'b0; tick = 1'b0;
        repeat (10) doTick();
        @(negedge clk);
        checkOutput("reset_held", 4'd0, O_REST);
        rst = 1'b0;
        runTicks(2);
        checkOutput("idle_no_start", 4'd0, O_REST);

        // Full nominal sequence.
        startSeq();
        checkOutput("clear_entry", 4'd1, O_CLEAR);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].exp_state, vecs[i].exp_out);
        end

        // Tape never arrives: timeout on the 50th tick edge in WAIT_TT.
        doReset();
        startSeq();
        runTicks(18);
        checkOutput("to_wait_tt", 4'd7, O_REST);
        runTicks(49);
        checkOutput("timeout_minus1", 4'd7, O_REST);
        runTicks(1);
        checkOutput("timeout", 4'd15, O_FAULT);
        runTicks(3);
        checkOutput("fault_hold", 4'd15, O_FAULT);

        // WAIT stuck high: no advance, then timeout, then abort.
        doReset();
        startSeq();
        runTicks(18);
        pl6 = 1'b1;
        runTicks(49);
        checkOutput("stuck_wait", 4'd7, O_REST);
        runTicks(1);
        checkOutput("stuck_timeout", 4'd15, O_FAULT);
        @(negedge clk) abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_fault", 4'd0, O_REST);
        abort = 1'b0; pl6 = 1'b0;

        // Abort in OP, with start held so release restarts at CLEAR.
        doReset();
        startSeq();
        runTicks(6);
        checkOutput("in_op", 4'd3, O_OP);
        @(negedge clk) begin abort = 1'b1; start = 1'b1; end
        @(negedge clk);
        checkOutput("abort_op", 4'd0, O_REST);
        abort = 1'b0;
        @(negedge clk);
        checkOutput("restart", 4'd1, O_CLEAR);
        start = 1'b0;

        // A tick level held for five clocks counts as one edge.
        doReset();
        startSeq();
        @(negedge clk) tick = 1'b1;
        repeat (5) @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("tick_level_once", 4'd1, O_CLEAR);
        runTicks(1);
        checkOutput("tick_level_two", 4'd1, O_CLEAR);
        runTicks(1);
        checkOutput("tick_level_three", 4'd2, O_NOOP);

        // Completion and timeout on the same edge: completion wins.
        doReset();
        startSeq();
        runTicks(18);
        pl6 = 1'b1;
        runTicks(49);
        checkOutput("race_pre", 4'd7, O_REST);
        @(negedge clk) begin tick = 1'b1; pl6 = 1'b0; end
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        checkOutput("race_completion", 4'd8, O_REST);

        checks++;
        if (inv_bad != 0) begin
            errors++;
            $display("[TB] FAIL invariants: got %0d violations expected 0", inv_bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
